// File: rtl/stream_arb_pkg.sv
// Shared types and the round-robin search used by stream_rr_arbiter.
package stream_arb_pkg;

    localparam int BEAT_DATA_W = 64;  // widest supported WIDTH
    localparam int MAX_REQ     = 16;
    localparam int SRC_W       = 4;

    typedef struct packed {
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
        logic [SRC_W-1:0]       src;
    } beat_t;

    typedef struct packed {
        logic             found;
        logic [SRC_W-1:0] idx;
    } pick_t;

    // First valid index at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [SRC_W-1:0]   ptr,
                                      input int                 n);
        pick_t          p;
        logic [SRC_W:0] j;
        p = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            j = {1'b0, ptr} + (SRC_W+1)'(i);
            if (j >= (SRC_W+1)'(n))
                j = j - (SRC_W+1)'(n);
            if (i < n && !p.found && valid[j[SRC_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[SRC_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_grant_rotator.sv
// Round-robin pointer and grant/ready decode. STREAM_ARB_PKT_LOCK_EN holds
// the grant on one requester until its last beat is accepted.
module rr_grant_rotator
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [NUM_REQ-1:0] req_last_i,
    input  logic               accept_ok_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               accept_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_next;
    pick_t            pick;

`ifdef STREAM_ARB_PKT_LOCK_EN
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
`endif

    always_comb begin
        pick = rr_pick(MAX_REQ'(req_valid_i), SRC_W'(ptr_q), NUM_REQ);
`ifdef STREAM_ARB_PKT_LOCK_EN
        if (lock_q) begin
            pick.found = req_valid_i[lock_idx_q];
            pick.idx   = SRC_W'(lock_idx_q);
        end
`endif
        grant_idx_o = pick.idx[IDX_W-1:0];
        accept_o    = pick.found & accept_ok_i;
        req_ready_o = accept_o ? (NUM_REQ'(1) << grant_idx_o) : '0;
        ptr_next    = (grant_idx_o == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx_o + IDX_W'(1);
    end

`ifdef STREAM_ARB_PKT_LOCK_EN
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept_o) begin
            if (!req_last_i[grant_idx_o]) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant_idx_o;
            end else begin
                lock_q <= 1'b0;
                ptr_q  <= ptr_next;
            end
        end
    end

    logic unused_pick;
    assign unused_pick = ^pick.idx;
`else
    always_ff @(posedge clk_i) begin
        if (clear_i)
            ptr_q <= '0;
        else if (accept_o)
            ptr_q <= ptr_next;
    end

    logic unused_pick;
    assign unused_pick = ^{pick.idx, req_last_i};
`endif

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 valid/ready mux with registered output plus skid entry.
// Define STREAM_ARB_PKT_LOCK_EN to keep grants for whole packets.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     clear_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic                     output_valid_o,
    input  logic                     output_ready_i,
    output logic [WIDTH-1:0]         output_data_o,
    output logic                     output_last_o,
    output logic [IDX_W-1:0]         output_src_o
);

    logic             accept_ok_q;
    logic             accept;
    logic [IDX_W-1:0] grant_idx;
    beat_t            acc_beat, out_q, skid_q;
    logic             out_vld_q, skid_vld_q;
    logic             load_out, skid_vld_d;

    rr_grant_rotator #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rot (
        .clk_i       (clk_i),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .accept_ok_i (accept_ok_q),
        .req_ready_o (req_ready_o),
        .grant_idx_o (grant_idx),
        .accept_o    (accept)
    );

    always_comb begin
        acc_beat.data = BEAT_DATA_W'(req_data_i[grant_idx*WIDTH +: WIDTH]);
        acc_beat.last = req_last_i[grant_idx];
        acc_beat.src  = SRC_W'(grant_idx);
        load_out      = !out_vld_q || output_ready_i;
        // A full skid entry always empties into the output register first.
        skid_vld_d    = load_out ? 1'b0 : (skid_vld_q || accept);
    end

    // accept_ok tracks skid emptiness one cycle ahead, so ready never sees output_ready_i.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            out_vld_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
            accept_ok_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            accept_ok_q <= !skid_vld_d;
            if (load_out) begin
                if (skid_vld_q) begin
                    out_q     <= skid_q;
                    out_vld_q <= 1'b1;
                end else if (accept) begin
                    out_q     <= acc_beat;
                    out_vld_q <= 1'b1;
                end else begin
                    out_vld_q <= 1'b0;
                end
            end else if (accept) begin
                skid_q <= acc_beat;
            end
        end
    end

    assign output_valid_o = out_vld_q;
    assign output_data_o  = out_q.data[WIDTH-1:0];
    assign output_last_o  = out_q.last;
    assign output_src_o   = out_q.src[IDX_W-1:0];

    logic unused_hi;
    assign unused_hi = ^{out_q.data, out_q.src};

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one registered valid/ready output stream between NUM_REQ valid/ready requesters using round-robin arbitration.
- Feeds the pipeline skid buffer stage downstream of it.
- Arbitration and the output register/skid register are fully pipelined: one beat per cycle sustained, no combinational path from output_ready_i to any input_ready_o.

Parameters:
- WIDTH, 32, data width of each requester and the output
- NUM_REQ, 4, number of requesters, 2..16
- IDX_W, $clog2(NUM_REQ), width of requester index (derived; not overridden)

Ports:
- clk_i  in  1  clock
- clear_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester valid
- req_ready_o  out  NUM_REQ  per-requester ready; at most one bit high
- req_data_i  in  NUM_REQ*WIDTH  packed requester data, requester k at [k*WIDTH +: WIDTH]
- req_last_i  in  NUM_REQ  per-requester end-of-packet flag
- output_valid_o  out  1  output valid
- output_ready_i  in  1  output ready
- output_data_o  out  WIDTH  output data
- output_last_o  out  1  last flag of the current output beat
- output_src_o  out  IDX_W  requester index of the current output beat

Behaviour:
- Reset: clear_i sampled at the clock edge.
  - Forces output_valid_o=0, output_data_o=0, output_last_o=0, output_src_o=0.
  - Skid register empty, round-robin pointer=0, lock released.
  - req_ready_o=0 in the cycle clear_i is high; it rises the cycle after clear_i falls.
  - Reset mid-transfer discards any buffered beats; no beat is emitted after reset.
- Internal storage is two entries: output register plus skid register. Each holds data, last and src.
- accept_ok is a registered flag, equal to "skid register empty". req_ready_o is nonzero only when accept_ok=1.
- Grant selection (combinational, from registered state only):
  - The first k with req_valid_i[k]=1, searching from pointer, pointer+1, ... with wrap modulo NUM_REQ.
  - req_ready_o[k]=accept_ok for the granted k; all other bits are 0.
  - If no requester is valid, req_ready_o is all 0.
  - Ready never depends on output_ready_i.
- Transfer: a beat is accepted on req_valid_i[k] & req_ready_o[k].
  - Pointer updates to (k+1) mod NUM_REQ on every accepted beat.
  - With no accept, the pointer holds.
- Latency: an accepted beat appears on output_* the next cycle if the output register was empty or drained in that same cycle. Otherwise it goes to the skid register.
- Output handshake: the output register advances on output_valid_o & output_ready_i, loading from the skid register if full, else from the accepted beat, else going empty.
- Simultaneous accept and drain with the skid register full cannot occur, because accept_ok=0.
- While output_valid_o=1 & output_ready_i=0, output_data_o, output_last_o and output_src_o are held stable.
- Full throughput: a single continuously valid requester with output_ready_i=1 streams one beat per cycle.
- Fairness: with all requesters continuously valid and the output always ready, grants cycle 0,1,2,...,NUM_REQ-1,0,...
- Backpressure: after output_ready_i falls, at most one further beat is accepted (into the skid register). accept_ok then drops next cycle.

Optional Feature:
- Macro: STREAM_ARB_PKT_LOCK_EN.
- Defined:
  - When a granted beat with last=0 is accepted, the grant locks to that requester.
  - The pointer does not advance, and other requesters get no ready until that requester's beat with last=1 is accepted.
  - The pointer then moves to (k+1) mod NUM_REQ.
  - A locked requester deasserting valid keeps the lock; there is no timeout.
  - Lock is cleared by clear_i.
- Undefined:
  - Arbitration is per beat; last is carried through to output_last_o only.
  - No lock register exists.

Decomposition:
- Package stream_arb_pkg holds typedef beat_t {data, last, src} with parameterized width via a localparam.
- The package also holds the function rr_pick(valid, pointer) returning the granted index plus a found flag.
- One sub-module: rr_grant_rotator. It contains the pointer register, the lock register (under the macro) and the grant/ready decode.
- The two-entry output storage stays in the top module.

Test Plan:
- Reset mid-stream: assert clear_i with both registers full -> next cycle output_valid_o=0, output_data_o=0, req_ready_o=0; first post-reset grant goes to requester 0 when all are valid.
- Round-robin: NUM_REQ=4, all valid, output_ready_i=1 -> output_src_o sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles; output_data_o matches requester data.
- Sparse requesters: only requesters 1 and 3 valid, pointer=2 -> grant 3 then 1 then 3; requester 0 and 2 ready bits stay 0.
- Backpressure: streaming requester 2 with data 0xA0,0xA1,0xA2; drop output_ready_i for 3 cycles after 0xA0 is shown -> 0xA1 is held in skid, req_ready_o=0 for those cycles, no loss or duplication, and 0xA1,0xA2 follow in order on release.
- Idle: no valid inputs -> req_ready_o=0, output_valid_o falls after the last beat drains, pointer unchanged.
- With STREAM_ARB_PKT_LOCK_EN: requester 1 sends 3 beats (last on the third) while requester 2 is valid -> output_src_o=1,1,1, then 2; without the macro -> 1,2,1,2 interleaved.
